ex_stage: RTL and testbench

- Execute stage of the 5-stage RV32 pipeline. Consumes the ID/EX register outputs and performs:
  - operand forwarding selection;
  - ALU operation;
  - branch/jump resolution.
- Registers its results into the EX/MEM pipeline register.
- Owns a 32-cycle iterative multiplier. While it runs, the block raises StallE to the hazard unit.

---
 rtl/ex_pkg.sv | 27 ++
 rtl/ex_stage_if.sv | 54 +++++
 rtl/ex_stage_iter_mul.sv | 73 +++++++
 rtl/ex_stage.sv | 144 ++++++++++++++
 tb/tb_ex_stage.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ex_pkg.sv
// Shared definitions for the RV32 execute stage: ALU op codes,
// forwarding select codes and the iterative multiplier state encoding.
package ex_pkg;

    // ALU operation codes driven by the decoder on ALUControlE
    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_SLT  = 3'b101;
    localparam logic [2:0] ALU_SLTU = 3'b110;
    localparam logic [2:0] ALU_MUL  = 3'b111;

    // Operand forwarding selects; code 2'b11 is treated like FWD_RF
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // Iterative multiplier states
    typedef enum logic [1:0] {
        MUL_IDLE = 2'b00,
        MUL_BUSY = 2'b01,
        MUL_DONE = 2'b10
    } mul_state_t;

endpackage

// File: rtl/ex_stage_if.sv
// Bundle of ID/EX inputs, forwarding inputs, redirect/stall outputs and
// EX/MEM register outputs of the execute stage. The slave modport is the
// execute stage itself; the master modport is whoever drives it.
interface ex_stage_if #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
);
    logic [1:0]      ResultSrcE;
    logic            MemWriteE;
    logic [2:0]      ALUControlE;
    logic            ALUSrcE;
    logic            RegWriteE;
    logic            JumpE;
    logic            BranchE;
    logic            JALRSrcE;
    logic            BranchSrcE;
    logic [XLEN-1:0] PCE;
    logic [XLEN-1:0] PCPlus4E;
    logic [XLEN-1:0] RD1E;
    logic [XLEN-1:0] RD2E;
    logic [XLEN-1:0] ExtImmE;
    logic [RA_W-1:0] RdE;
    logic [1:0]      ForwardAE;
    logic [1:0]      ForwardBE;
    logic [XLEN-1:0] ResultW;

    logic            PCSrcE;
    logic [XLEN-1:0] PCTargetE;
    logic            StallE;
    logic            RegWriteM;
    logic            MemWriteM;
    logic [1:0]      ResultSrcM;
    logic [XLEN-1:0] ALUResultM;
    logic [XLEN-1:0] WriteDataM;
    logic [XLEN-1:0] PCPlus4M;
    logic [RA_W-1:0] RdM;

    modport slave (
        input  ResultSrcE, MemWriteE, ALUControlE, ALUSrcE, RegWriteE,
               JumpE, BranchE, JALRSrcE, BranchSrcE, PCE, PCPlus4E,
               RD1E, RD2E, ExtImmE, RdE, ForwardAE, ForwardBE, ResultW,
        output PCSrcE, PCTargetE, StallE, RegWriteM, MemWriteM, ResultSrcM,
               ALUResultM, WriteDataM, PCPlus4M, RdM
    );

    modport master (
        output ResultSrcE, MemWriteE, ALUControlE, ALUSrcE, RegWriteE,
               JumpE, BranchE, JALRSrcE, BranchSrcE, PCE, PCPlus4E,
               RD1E, RD2E, ExtImmE, RdE, ForwardAE, ForwardBE, ResultW,
        input  PCSrcE, PCTargetE, StallE, RegWriteM, MemWriteM, ResultSrcM,
               ALUResultM, WriteDataM, PCPlus4M, RdM
    );

endinterface

// File: rtl/ex_stage_iter_mul.sv
// Iterative shift-add multiplier (module iter_mul). Operands are latched
// when start is seen in IDLE, then one multiplier bit is consumed per
// BUSY cycle for XLEN cycles, followed by a single DONE cycle in which
// product holds the low XLEN bits of a*b.
module iter_mul
    import ex_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] product
);

    localparam int CW = $clog2(XLEN);

    mul_state_t      state;
    logic [XLEN-1:0] multiplicand;
    logic [XLEN-1:0] multiplier;
    logic [XLEN-1:0] accumulator;
    logic [CW-1:0]   count;

    // FSM plus shift-add datapath; reset abandons any multiply in flight
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= MUL_IDLE;
            count        <= '0;
            multiplicand <= '0;
            multiplier   <= '0;
            accumulator  <= '0;
        end else begin
            case (state)
                MUL_IDLE: begin
                    if (start) begin
                        multiplicand <= a;
                        multiplier   <= b;
                        accumulator  <= '0;
                        count        <= '0;
                        state        <= MUL_BUSY;
                    end
                end
                MUL_BUSY: begin
                    if (multiplier[0]) begin
                        accumulator <= accumulator + multiplicand;
                    end
                    multiplicand <= multiplicand << 1;
                    multiplier   <= multiplier >> 1;
                    count        <= count + 1'b1;
                    if (count == CW'(XLEN - 1)) begin
                        state <= MUL_DONE;
                    end
                end
                MUL_DONE: begin
                    state <= MUL_IDLE;
                end
                default: begin
                    state <= MUL_IDLE;
                end
            endcase
        end
    end

    // The start cycle already stalls so the operands stay put while latched
    assign busy    = ((state == MUL_IDLE) && start) || (state == MUL_BUSY);
    assign done    = (state == MUL_DONE);
    assign product = accumulator;

endmodule

// File: rtl/ex_stage.sv
// Execute stage of the 5-stage RV32 pipeline: forwarding muxes, ALU,
// branch/jump resolution and the EX/MEM pipeline register.
// Build option FAST_MUL_EN: when defined, MUL is a single-cycle
// combinational product and StallE is tied low; otherwise MUL uses the
// iterative iter_mul unit and stalls the front of the pipe while it runs.
module ex_stage
    import ex_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input logic       clk,
    input logic       rst,
    ex_stage_if.slave bus
);

    logic [XLEN-1:0] SrcAE;
    logic [XLEN-1:0] SrcBE;
    logic [XLEN-1:0] WriteDataE;
    logic [XLEN-1:0] diffAB;
    logic [XLEN-1:0] jalrSum;
    logic            ZeroE;
    logic            branchCond;
    logic [XLEN-1:0] aluResultE;
    logic [XLEN-1:0] mulResult;
    logic            StallE;

    logic            regWriteM;
    logic            memWriteM;
    logic [1:0]      resultSrcM;
    logic [XLEN-1:0] aluResultM;
    logic [XLEN-1:0] writeDataM;
    logic [XLEN-1:0] pcPlus4M;
    logic [RA_W-1:0] rdM;

    // Forwarding muxes for both register operands, then the immediate mux
    always_comb begin
        SrcAE      = bus.RD1E;
        WriteDataE = bus.RD2E;
        case (bus.ForwardAE)
            FWD_WB:  SrcAE = bus.ResultW;
            FWD_MEM: SrcAE = aluResultM;
            default: SrcAE = bus.RD1E;
        endcase
        case (bus.ForwardBE)
            FWD_WB:  WriteDataE = bus.ResultW;
            FWD_MEM: WriteDataE = aluResultM;
            default: WriteDataE = bus.RD2E;
        endcase
        SrcBE = bus.ALUSrcE ? bus.ExtImmE : WriteDataE;
    end

    assign diffAB = SrcAE - SrcBE;

`ifdef FAST_MUL_EN
    assign mulResult = SrcAE * SrcBE;
    assign StallE    = 1'b0;
`else
    logic            mulBusy;
    logic            mulDone;
    logic [XLEN-1:0] mulProduct;

    iter_mul #(
        .XLEN (XLEN)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (bus.ALUControlE == ALU_MUL),
        .a       (SrcAE),
        .b       (SrcBE),
        .busy    (mulBusy),
        .done    (mulDone),
        .product (mulProduct)
    );

    assign StallE    = mulBusy;
    assign mulResult = mulDone ? mulProduct : '0;
`endif

    // ALU result selection; all arithmetic wraps at XLEN bits
    always_comb begin
        aluResultE = '0;
        case (bus.ALUControlE)
            ALU_ADD:  aluResultE = SrcAE + SrcBE;
            ALU_SUB:  aluResultE = diffAB;
            ALU_AND:  aluResultE = SrcAE & SrcBE;
            ALU_OR:   aluResultE = SrcAE | SrcBE;
            ALU_XOR:  aluResultE = SrcAE ^ SrcBE;
            ALU_SLT:  aluResultE = {{(XLEN-1){1'b0}}, ($signed(SrcAE) < $signed(SrcBE))};
            ALU_SLTU: aluResultE = {{(XLEN-1){1'b0}}, (SrcAE < SrcBE)};
            ALU_MUL:  aluResultE = mulResult;
            default:  aluResultE = '0;
        endcase
    end

    // Branch/jump resolution: BEQ/BNE from the subtract, JALR clears bit 0
    always_comb begin
        ZeroE         = (diffAB == '0);
        branchCond    = bus.BranchSrcE ? !ZeroE : ZeroE;
        jalrSum       = SrcAE + bus.ExtImmE;
        bus.PCSrcE    = bus.JumpE | (bus.BranchE & branchCond);
        bus.PCTargetE = bus.JALRSrcE ? {jalrSum[XLEN-1:1], 1'b0}
                                     : (bus.PCE + bus.ExtImmE);
    end

    // EX/MEM register: captures E values, or a bubble while stalled
    always_ff @(posedge clk) begin
        if (!rst) begin
            regWriteM  <= 1'b0;
            memWriteM  <= 1'b0;
            resultSrcM <= '0;
            aluResultM <= '0;
            writeDataM <= '0;
            pcPlus4M   <= '0;
            rdM        <= '0;
        end else if (StallE) begin
            regWriteM  <= 1'b0;
            memWriteM  <= 1'b0;
            resultSrcM <= '0;
            aluResultM <= '0;
            writeDataM <= '0;
            pcPlus4M   <= '0;
            rdM        <= '0;
        end else begin
            regWriteM  <= bus.RegWriteE;
            memWriteM  <= bus.MemWriteE;
            resultSrcM <= bus.ResultSrcE;
            aluResultM <= aluResultE;
            writeDataM <= WriteDataE;
            pcPlus4M   <= bus.PCPlus4E;
            rdM        <= bus.RdE;
        end
    end

    assign bus.StallE     = StallE;
    assign bus.RegWriteM  = regWriteM;
    assign bus.MemWriteM  = memWriteM;
    assign bus.ResultSrcM = resultSrcM;
    assign bus.ALUResultM = aluResultM;
    assign bus.WriteDataM = writeDataM;
    assign bus.PCPlus4M   = pcPlus4M;
    assign bus.RdM        = rdM;

endmodule

// File: tb/tb_ex_stage.sv
// Directed testbench for ex_stage: a table of single-cycle ALU/branch
// vectors followed by hand sequences for forwarding from MEM, the
// multi-cycle multiplier and reset during a multiply.
module tb_ex_stage;
    import ex_pkg::*;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    ex_stage_if bus ();

    ex_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, 10 time units per period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so the run can never hang
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    typedef struct {
        string       name;
        logic [2:0]  ctl;
        logic        aluSrc;
        logic [1:0]  fwdA;
        logic [1:0]  fwdB;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [31:0] resW;
        logic [31:0] pc;
        logic        jump;
        logic        branch;
        logic        brSrc;
        logic        jalr;
        logic [31:0] expResult;
        logic [31:0] expWData;
        logic [31:0] expTarget;
        logic        expPCSrc;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs[NV];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        bus.ResultSrcE  = 2'b00;
        bus.MemWriteE   = 1'b0;
        bus.ALUControlE = ALU_ADD;
        bus.ALUSrcE     = 1'b0;
        bus.RegWriteE   = 1'b0;
        bus.JumpE       = 1'b0;
        bus.BranchE     = 1'b0;
        bus.JALRSrcE    = 1'b0;
        bus.BranchSrcE  = 1'b0;
        bus.PCE         = 32'h0;
        bus.PCPlus4E    = 32'h0;
        bus.RD1E        = 32'h0;
        bus.RD2E        = 32'h0;
        bus.ExtImmE     = 32'h0;
        bus.RdE         = 5'd0;
        bus.ForwardAE   = FWD_RF;
        bus.ForwardBE   = FWD_RF;
        bus.ResultW     = 32'h0;
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        bus.ALUControlE = v.ctl;
        bus.ALUSrcE     = v.aluSrc;
        bus.ForwardAE   = v.fwdA;
        bus.ForwardBE   = v.fwdB;
        bus.RD1E        = v.rd1;
        bus.RD2E        = v.rd2;
        bus.ExtImmE     = v.imm;
        bus.ResultW     = v.resW;
        bus.PCE         = v.pc;
        bus.PCPlus4E    = v.pc + 32'd4;
        bus.JumpE       = v.jump;
        bus.BranchE     = v.branch;
        bus.BranchSrcE  = v.brSrc;
        bus.JALRSrcE    = v.jalr;
        bus.RegWriteE   = 1'b1;
        bus.MemWriteE   = idx[0];
        bus.ResultSrcE  = idx[1:0];
        bus.RdE         = 5'(idx + 1);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " StallE"},     32'(bus.StallE),     32'h0);
        checkOutput({tag, " RegWriteM"},  32'(bus.RegWriteM),  32'h0);
        checkOutput({tag, " MemWriteM"},  32'(bus.MemWriteM),  32'h0);
        checkOutput({tag, " ResultSrcM"}, 32'(bus.ResultSrcM), 32'h0);
        checkOutput({tag, " ALUResultM"}, bus.ALUResultM,      32'h0);
        checkOutput({tag, " WriteDataM"}, bus.WriteDataM,      32'h0);
        checkOutput({tag, " PCPlus4M"},   bus.PCPlus4M,        32'h0);
        checkOutput({tag, " RdM"},        32'(bus.RdM),        32'h0);
    endtask

    // Multiply a*b; with useWb the A operand comes from ResultW, which is
    // then disturbed partway through the stall
    task automatic runMul(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic useWb, input logic [31:0] expected);
        int stallCycles;
        int cyc;
        clearInputs();
        bus.ALUControlE = ALU_MUL;
        bus.RegWriteE   = 1'b1;
        bus.RdE         = 5'd9;
        bus.RD2E        = b;
        bus.PCPlus4E    = 32'h444;
        if (useWb) begin
            bus.ForwardAE = FWD_WB;
            bus.ResultW   = a;
            bus.RD1E      = 32'h0;
        end else begin
            bus.RD1E = a;
        end
        #1;
`ifdef FAST_MUL_EN
        checkOutput({name, " StallE"}, 32'(bus.StallE), 32'h0);
        tick();
        checkOutput({name, " ALUResultM"}, bus.ALUResultM,     expected);
        checkOutput({name, " RegWriteM"},  32'(bus.RegWriteM), 32'h1);
        checkOutput({name, " StallE after"}, 32'(bus.StallE),  32'h0);
        cyc = 0;
        stallCycles = 0;
`else
        stallCycles = 0;
        cyc = 0;
        while (bus.StallE === 1'b1 && cyc < 100) begin
            stallCycles++;
            if (useWb && stallCycles == 5) begin
                bus.ResultW = 32'h55;
            end
            tick();
            cyc++;
            checkOutput({name, " RegWriteM during stall"}, 32'(bus.RegWriteM), 32'h0);
        end
        if (cyc >= 100) begin
            errors++;
            checks++;
            $display("[TB] FAIL %s timeout: got StallE still high expected release", name);
        end
        checkOutput({name, " stall cycles"}, 32'(stallCycles), 32'd33);
        tick();
        bus.ALUControlE = ALU_ADD;
        bus.RegWriteE   = 1'b0;
        checkOutput({name, " ALUResultM"}, bus.ALUResultM,     expected);
        checkOutput({name, " RegWriteM"},  32'(bus.RegWriteM), 32'h1);
        checkOutput({name, " RdM"},        32'(bus.RdM),       32'd9);
        checkOutput({name, " PCPlus4M"},   bus.PCPlus4M,       32'h444);
`endif
        tick();
    endtask

    initial begin
        errors = 0;
        checks = 0;

        vecs[0]  = '{"add",    ALU_ADD,  1'b0, 2'b00, 2'b00, 32'h3,        32'h4,        32'h0,   32'h0,   32'h200, 1'b0, 1'b0, 1'b0, 1'b0, 32'h7,        32'h4,        32'h200,  1'b0};
        vecs[1]  = '{"sub",    ALU_SUB,  1'b0, 2'b00, 2'b00, 32'h5,        32'h7,        32'h0,   32'h0,   32'h200, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFE, 32'h7,        32'h200,  1'b0};
        vecs[2]  = '{"and",    ALU_AND,  1'b0, 2'b00, 2'b00, 32'hF0F0,     32'hFF00,     32'h0,   32'h0,   32'h200, 1'b0, 1'b0, 1'b0, 1'b0, 32'hF000,     32'hFF00,     32'h200,  1'b0};
        vecs[3]  = '{"or",     ALU_OR,   1'b0, 2'b00, 2'b00, 32'hF0F0,     32'hFF00,     32'h0,   32'h0,   32'h200, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFFF0,     32'hFF00,     32'h200,  1'b0};
        vecs[4]  = '{"xor",    ALU_XOR,  1'b0, 2'b00, 2'b00, 32'hFF00,     32'h0FF0,     32'h0,   32'h0,   32'h200, 1'b0, 1'b0, 1'b0, 1'b0, 32'hF0F0,     32'h0FF0,     32'h200,  1'b0};
        vecs[5]  = '{"slt",    ALU_SLT,  1'b0, 2'b00, 2'b00, 32'hFFFFFFFF, 32'h1,        32'h0,   32'h0,   32'h200, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1,        32'h1,        32'h200,  1'b0};
        vecs[6]  = '{"sltu",   ALU_SLTU, 1'b0, 2'b00, 2'b00, 32'hFFFFFFFF, 32'h1,        32'h0,   32'h0,   32'h200, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h1,        32'h200,  1'b0};
        vecs[7]  = '{"addi",   ALU_ADD,  1'b1, 2'b00, 2'b00, 32'h23,       32'h77,       32'h100, 32'h0,   32'h200, 1'b0, 1'b0, 1'b0, 1'b0, 32'h123,      32'h77,       32'h300,  1'b0};
        vecs[8]  = '{"fwd_wb", ALU_ADD,  1'b0, 2'b00, 2'b01, 32'h2,        32'h999,      32'h0,   32'h40,  32'h200, 1'b0, 1'b0, 1'b0, 1'b0, 32'h42,       32'h40,       32'h200,  1'b0};
        vecs[9]  = '{"fwd_11", ALU_ADD,  1'b0, 2'b11, 2'b00, 32'h10,       32'h1,        32'h0,   32'h500, 32'h200, 1'b0, 1'b0, 1'b0, 1'b0, 32'h11,       32'h1,        32'h200,  1'b0};
        vecs[10] = '{"beq",    ALU_SUB,  1'b0, 2'b00, 2'b00, 32'h7,        32'h7,        32'h20,  32'h0,   32'h100, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h7,        32'h120,  1'b1};
        vecs[11] = '{"bne",    ALU_SUB,  1'b0, 2'b00, 2'b00, 32'h7,        32'h7,        32'h20,  32'h0,   32'h100, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        32'h7,        32'h120,  1'b0};
        vecs[12] = '{"jalr",   ALU_ADD,  1'b1, 2'b00, 2'b00, 32'h1001,     32'h0,        32'h4,   32'h0,   32'h100, 1'b1, 1'b0, 1'b0, 1'b1, 32'h1005,     32'h0,        32'h1004, 1'b1};
        vecs[13] = '{"beq_nt", ALU_SUB,  1'b0, 2'b00, 2'b00, 32'h7,        32'h8,        32'h20,  32'h0,   32'h100, 1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h8,        32'h120,  1'b0};
        vecs[14] = '{"slt_n",  ALU_SLT,  1'b0, 2'b00, 2'b00, 32'h1,        32'hFFFFFFFF, 32'h0,   32'h0,   32'h200, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'hFFFFFFFF, 32'h200,  1'b0};
        vecs[15] = '{"sltu_n", ALU_SLTU, 1'b0, 2'b00, 2'b00, 32'h1,        32'hFFFFFFFF, 32'h0,   32'h0,   32'h200, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1,        32'hFFFFFFFF, 32'h200,  1'b0};

        // Reset with live-looking inputs: EX/MEM must still read all zero
        rst = 1'b0;
        clearInputs();
        bus.RegWriteE = 1'b1;
        bus.MemWriteE = 1'b1;
        bus.RD1E      = 32'h5;
        bus.RD2E      = 32'h6;
        bus.RdE       = 5'd3;
        bus.PCPlus4E  = 32'h104;
        tick();
        tick();
        checkAllZero("reset");
        rst = 1'b1;
        clearInputs();
        tick();

        // Table of single-cycle operations
        for (int i = 0; i < NV; i++) begin
            applyStimulus(vecs[i], i);
            #1;
            checkOutput($sformatf("%s PCSrcE", vecs[i].name),    32'(bus.PCSrcE), 32'(vecs[i].expPCSrc));
            checkOutput($sformatf("%s PCTargetE", vecs[i].name), bus.PCTargetE,   vecs[i].expTarget);
            checkOutput($sformatf("%s StallE", vecs[i].name),    32'(bus.StallE), 32'h0);
            tick();
            checkOutput($sformatf("%s ALUResultM", vecs[i].name), bus.ALUResultM,      vecs[i].expResult);
            checkOutput($sformatf("%s WriteDataM", vecs[i].name), bus.WriteDataM,      vecs[i].expWData);
            checkOutput($sformatf("%s RdM", vecs[i].name),        32'(bus.RdM),        32'(i + 1));
            checkOutput($sformatf("%s RegWriteM", vecs[i].name),  32'(bus.RegWriteM),  32'h1);
            checkOutput($sformatf("%s MemWriteM", vecs[i].name),  32'(bus.MemWriteM),  32'(i % 2));
            checkOutput($sformatf("%s ResultSrcM", vecs[i].name), 32'(bus.ResultSrcM), 32'(i % 4));
            checkOutput($sformatf("%s PCPlus4M", vecs[i].name),   bus.PCPlus4M,        vecs[i].pc + 32'd4);
        end

        // Forwarding from MEM: produce 0x10, then consume it as SrcA
        clearInputs();
        bus.RD1E      = 32'h8;
        bus.RD2E      = 32'h8;
        bus.RegWriteE = 1'b1;
        bus.RdE       = 5'd4;
        tick();
        checkOutput("fwd_mem setup ALUResultM", bus.ALUResultM, 32'h10);
        bus.ForwardAE = FWD_MEM;
        bus.RD1E      = 32'hDEAD;
        bus.RD2E      = 32'h5;
        bus.RdE       = 5'd7;
        tick();
        checkOutput("fwd_mem ALUResultM", bus.ALUResultM,     32'h15);
        checkOutput("fwd_mem RdM",        32'(bus.RdM),       32'd7);
        checkOutput("fwd_mem RegWriteM",  32'(bus.RegWriteM), 32'h1);

        // Multiplier sequences
        runMul("mul7x6",   32'h7,        32'h6, 1'b0, 32'd42);
        runMul("mulwrap",  32'hFFFFFFFF, 32'h2, 1'b0, 32'hFFFFFFFE);
        runMul("mulfwdwb", 32'h7,        32'h6, 1'b1, 32'd42);

`ifndef FAST_MUL_EN
        // Reset asserted in the tenth BUSY cycle aborts the multiply
        begin
            int stallSeen;
            clearInputs();
            bus.ALUControlE = ALU_MUL;
            bus.RD1E        = 32'h7;
            bus.RD2E        = 32'h6;
            bus.RegWriteE   = 1'b1;
            bus.RdE         = 5'd9;
            tick();
            for (int k = 0; k < 9; k++) begin
                tick();
            end
            checkOutput("rstbusy StallE before", 32'(bus.StallE), 32'h1);
            rst = 1'b0;
            bus.ALUControlE = ALU_ADD;
            tick();
            checkAllZero("rstbusy");
            rst = 1'b1;
            bus.RD1E = 32'h1;
            bus.RD2E = 32'h2;
            stallSeen = 0;
            for (int k = 0; k < 40; k++) begin
                tick();
                if (bus.StallE === 1'b1) stallSeen++;
            end
            checkOutput("rstbusy stale stall", 32'(stallSeen), 32'h0);
            checkOutput("rstbusy ALUResultM after", bus.ALUResultM, 32'h3);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
